// File: rtl/digit_segment_renderer.sv
// Seven-segment hex glyph renderer: RGB444 pixel stream, two cycles behind the scan counters.
// Optional macro BLINK_EN: digit shown for 32 frames, then hidden for 32 frames.
module digit_segment_renderer #(
  parameter int unsigned SEG_LEN  = 20,
  parameter int unsigned SEG_W    = 4,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  DigitX,
  input  logic [9:0]  DigitY,
  input  logic [3:0]  Value,
  input  logic [9:0]  PixelX,
  input  logic [9:0]  PixelY,
  input  logic        VideoOn,
  output logic [11:0] RGB,
  output logic        Hit
);

  localparam int unsigned GlyphW = SEG_LEN + 2 * SEG_W;
  localparam int unsigned GlyphH = 2 * SEG_LEN + 3 * SEG_W;

  // Column and row band edges of the glyph box, in box-relative pixels.
  localparam logic [10:0] X1 = 11'(SEG_W);
  localparam logic [10:0] X2 = 11'(SEG_W + SEG_LEN);
  localparam logic [10:0] X3 = 11'(GlyphW);
  localparam logic [10:0] Y1 = 11'(SEG_W);
  localparam logic [10:0] Y2 = 11'(SEG_W + SEG_LEN);
  localparam logic [10:0] Y3 = 11'(SEG_LEN + 2 * SEG_W);
  localparam logic [10:0] Y4 = 11'(2 * SEG_LEN + 2 * SEG_W);
  localparam logic [10:0] Y5 = 11'(GlyphH);

  // Frame latch on the first blanking line keeps position/value stable for a whole frame.
  logic       latch;
  logic [9:0] lx_q, ly_q;
  logic [3:0] lv_q;

  assign latch = (PixelX == 10'd0) && (PixelY == 10'd480);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lx_q <= '0;
      ly_q <= '0;
      lv_q <= '0;
    end else if (latch) begin
      lx_q <= DigitX;
      ly_q <= DigitY;
      lv_q <= Value;
    end
  end

  logic blank;

`ifdef BLINK_EN
  logic [5:0] frame_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
    end else if (latch) begin
      frame_cnt_q <= frame_cnt_q + 6'd1;
    end
  end

  assign blank = frame_cnt_q[5];
`else
  assign blank = 1'b0;
`endif

  // Stage 1: box-relative offsets and box membership, 11-bit so LX+W never overflows.
  logic [10:0] px, py, lx, ly;
  logic [10:0] dx_d, dy_d, dx_q, dy_q;
  logic        inbox_d, inbox_q, von_d1_q;

  assign px = {1'b0, PixelX};
  assign py = {1'b0, PixelY};
  assign lx = {1'b0, lx_q};
  assign ly = {1'b0, ly_q};

  assign dx_d    = px - lx;
  assign dy_d    = py - ly;
  assign inbox_d = (px >= lx) && (px < lx + X3) && (py >= ly) && (py < ly + Y5);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dx_q     <= '0;
      dy_q     <= '0;
      inbox_q  <= 1'b0;
      von_d1_q <= 1'b0;
    end else begin
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      inbox_q  <= inbox_d;
      von_d1_q <= VideoOn;
    end
  end

  // Stage 2: segment decode and region test.
  logic [6:0] seg;  // abcdefg, a in bit 6

  always_comb begin
    seg = 7'b0000000;
    unique case (lv_q)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
    endcase
  end

  logic row_top, row_up, row_mid, row_lo, row_bot;
  logic col_l, col_m, col_r;
  logic lit, hit_d, hit_q, von_d2_q;

  always_comb begin
    row_top = dy_q < Y1;
    row_up  = (dy_q >= Y1) && (dy_q < Y2);
    row_mid = (dy_q >= Y2) && (dy_q < Y3);
    row_lo  = (dy_q >= Y3) && (dy_q < Y4);
    row_bot = (dy_q >= Y4) && (dy_q < Y5);
    col_l   = dx_q < X1;
    col_m   = (dx_q >= X1) && (dx_q < X2);
    col_r   = (dx_q >= X2) && (dx_q < X3);
    lit     = (seg[6] && col_m && row_top) ||
              (seg[5] && col_r && row_up)  ||
              (seg[4] && col_r && row_lo)  ||
              (seg[3] && col_m && row_bot) ||
              (seg[2] && col_l && row_lo)  ||
              (seg[1] && col_l && row_up)  ||
              (seg[0] && col_m && row_mid);
    hit_d   = inbox_q && von_d1_q && lit && !blank;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_q    <= 1'b0;
      von_d2_q <= 1'b0;
    end else begin
      hit_q    <= hit_d;
      von_d2_q <= von_d1_q;
    end
  end

  // Driven straight from stage-2 registers so an asynchronous reset blanks the output at once.
  always_comb begin
    RGB = 12'h000;
    if (hit_q) begin
      RGB = FG_COLOR;
    end else if (von_d2_q) begin
      RGB = BG_COLOR;
    end
  end

  assign Hit = hit_q;

endmodule

// File: tb/tb_digit_segment_renderer.sv
// Self-checking bench for digit_segment_renderer: hand vectors, corner sequences and a
// randomized scan checked against a rectangle-based glyph model.
module tb_digit_segment_renderer;

  localparam int SL = 20;
  localparam int SW = 4;
  localparam int GW = SL + 2 * SW;
  localparam int GH = 2 * SL + 3 * SW;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h05A;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  DigitX = '0;
  logic [9:0]  DigitY = '0;
  logic [3:0]  Value = '0;
  logic [9:0]  PixelX = 10'd700;
  logic [9:0]  PixelY = 10'd700;
  logic        VideoOn = 1'b0;
  logic [11:0] RGB;
  logic        Hit;

  always #5 clock = ~clock;

  digit_segment_renderer #(
    .SEG_LEN (SL),
    .SEG_W   (SW),
    .FG_COLOR(FG),
    .BG_COLOR(BG)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .DigitX (DigitX),
    .DigitY (DigitY),
    .Value  (Value),
    .PixelX (PixelX),
    .PixelY (PixelY),
    .VideoOn(VideoOn),
    .RGB    (RGB),
    .Hit    (Hit)
  );

  int total = 0;
  int bad = 0;

  // Reference model state: shadow position/value and number of latch events.
  int m_lx = 0, m_ly = 0, m_lv = 0, m_frames = 0;
  logic [6:0] glyph[16];
  int rx0[7], rx1[7], ry0[7], ry1[7];  // segment rectangles a..g, half-open

  // Two-deep queue of expected outputs for pixels already driven.
  logic [12:0] exp1 = '0, exp2 = '0;
  bit pv1 = 1'b0, pv2 = 1'b0;
  int last_px = 0, last_py = 0;

  typedef struct {
    int dx; int dy; int dv;
    int px; int py; bit von;
    bit hit; logic [11:0] rgb;
    string name;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  function automatic logic [12:0] model_px(input int px, input int py, input bit von);
    int dx, dy;
    bit hit, hidden;
    dx = px - m_lx;
    dy = py - m_ly;
    hit = 1'b0;
    hidden = 1'b0;
`ifdef BLINK_EN
    hidden = ((m_frames / 32) % 2) == 1;
`endif
    if (von && !hidden && dx >= 0 && dx < GW && dy >= 0 && dy < GH) begin
      for (int s = 0; s < 7; s++) begin
        if (glyph[m_lv][6-s] && dx >= rx0[s] && dx < rx1[s] && dy >= ry0[s] && dy < ry1[s])
          hit = 1'b1;
      end
    end
    if (hit) return {1'b1, FG};
    if (von) return {1'b0, BG};
    return 13'h0;
  endfunction

  task automatic check_now(input string name, input logic [12:0] e);
    total++;
    if ({Hit, RGB} !== e) begin
      bad++;
      $display("FAIL %s t=%0t got hit=%0b rgb=%h want hit=%0b rgb=%h",
               name, $time, Hit, RGB, e[12], e[11:0]);
    end
  endtask

  // One pixel per clock: compare the output due now, then drive the next pixel.
  task automatic step(input int px, input int py, input bit von);
    logic [12:0] e;
    string nm;
    @(negedge clock);
    if (pv2) begin
      nm = $sformatf("stream(%0d,%0d)", last_px, last_py);
      check_now(nm, exp2);
    end
    e = model_px(px, py, von);
    PixelX = 10'(px);
    PixelY = 10'(py);
    VideoOn = von;
    if (px == 0 && py == 480) begin
      m_lx = int'(DigitX);
      m_ly = int'(DigitY);
      m_lv = int'(Value);
      m_frames++;
    end
    last_px = px;
    last_py = py;
    exp2 = exp1;
    pv2 = pv1;
    exp1 = e;
    pv1 = 1'b1;
  endtask

  task automatic idle2();
    step(700, 10, 1'b0);
    step(700, 10, 1'b0);
  endtask

  task automatic model_reset();
    m_lx = 0;
    m_ly = 0;
    m_lv = 0;
    m_frames = 0;
    exp1 = '0;
    exp2 = '0;
    pv1 = 1'b1;
    pv2 = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_now("async_reset", 13'h0);
    PixelX = 10'd700;
    PixelY = 10'd700;
    VideoOn = 1'b0;
    @(posedge clock);
    #1 check_now("reset_hold", 13'h0);
    @(negedge clock);
    #2 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    int px, py;
    bit von;

    glyph[0] = 7'b1111110; glyph[1] = 7'b0110000; glyph[2] = 7'b1101101; glyph[3] = 7'b1111001;
    glyph[4] = 7'b0110011; glyph[5] = 7'b1011011; glyph[6] = 7'b1011111; glyph[7] = 7'b1110000;
    glyph[8] = 7'b1111111; glyph[9] = 7'b1111011; glyph[10] = 7'b1110111; glyph[11] = 7'b0011111;
    glyph[12] = 7'b1001110; glyph[13] = 7'b0111101; glyph[14] = 7'b1001111;
    glyph[15] = 7'b1000111;
    // a, b, c, d, e, f, g
    rx0 = '{SW, SW+SL, SW+SL, SW, 0, 0, SW};
    rx1 = '{SW+SL, GW, GW, SW+SL, SW, SW, SW+SL};
    ry0 = '{0, SW, SL+2*SW, 2*SL+2*SW, SL+2*SW, SW, SL+SW};
    ry1 = '{SW, SW+SL, 2*SL+2*SW, GH, 2*SL+2*SW, SW+SL, SL+2*SW};

    vecs[0]  = '{0, 0, 0, 5, 1, 1'b1, 1'b1, FG, "zero_a"};
    vecs[1]  = '{0, 0, 0, 0, 0, 1'b1, 1'b0, BG, "zero_corner"};
    vecs[2]  = '{0, 0, 0, 14, 25, 1'b1, 1'b0, BG, "zero_g_off"};
    vecs[3]  = '{0, 0, 8, 10, 48, 1'b1, 1'b1, FG, "eight_d"};
    vecs[4]  = '{0, 0, 8, 10, 52, 1'b1, 1'b0, BG, "eight_below_box"};
    vecs[5]  = '{0, 0, 8, 0, 4, 1'b1, 1'b1, FG, "eight_f_edge"};
    vecs[6]  = '{0, 0, 8, 27, 51, 1'b1, 1'b0, BG, "eight_corner_br"};
    vecs[7]  = '{100, 200, 8, 114, 201, 1'b1, 1'b1, FG, "moved_a"};
    vecs[8]  = '{100, 200, 8, 99, 201, 1'b1, 1'b0, BG, "moved_left"};
    vecs[9]  = '{100, 200, 1, 104, 201, 1'b1, 1'b0, BG, "one_a_off"};
    vecs[10] = '{100, 200, 1, 125, 210, 1'b1, 1'b1, FG, "one_b_on"};
    vecs[11] = '{100, 200, 8, 114, 201, 1'b0, 1'b0, 12'h000, "video_off"};
    vecs[12] = '{620, 460, 8, 630, 461, 1'b1, 1'b1, FG, "clip_a"};
    vecs[13] = '{620, 460, 8, 2, 1, 1'b1, 1'b0, BG, "no_wrap"};
    vecs[14] = '{0, 0, 12, 25, 10, 1'b1, 1'b0, BG, "c_b_off"};
    vecs[15] = '{0, 0, 12, 1, 30, 1'b1, 1'b1, FG, "c_e_on"};

    // Reset state, then release away from the clock edge.
    repeat (3) @(posedge clock);
    #1 check_now("reset_state", 13'h0);
    @(negedge clock);
    #2 reset = 1'b1;
    model_reset();

    // Shadows are zero after reset: a "0" glyph at the origin.
    step(5, 1, 1'b1);
    idle2();
    check_now("rst_zero_a", {1'b1, FG});
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++)
        step(x, y, 1'b1);
    idle2();

    for (int i = 0; i < NV; i++) begin
      DigitX = 10'(vecs[i].dx);
      DigitY = 10'(vecs[i].dy);
      Value = 4'(vecs[i].dv);
      step(0, 480, 1'b0);
      step(vecs[i].px, vecs[i].py, vecs[i].von);
      idle2();
      check_now(vecs[i].name, {vecs[i].hit, vecs[i].rgb});
    end

    // Position change mid-frame must not move the glyph until the next latch point.
    DigitX = 10'd100; DigitY = 10'd200; Value = 4'h8;
    step(0, 480, 1'b0);
    for (int x = 0; x < 8; x++) step(x, 100, 1'b1);
    DigitX = 10'd300;
    step(114, 201, 1'b1);
    idle2();
    check_now("midframe_hold", {1'b1, FG});
    step(314, 201, 1'b1);
    idle2();
    check_now("midframe_not_moved", {1'b0, BG});
    step(0, 480, 1'b0);
    step(314, 201, 1'b1);
    idle2();
    check_now("moved_after_latch", {1'b1, FG});
    step(114, 201, 1'b1);
    idle2();
    check_now("old_pos_clear", {1'b0, BG});

    // Inputs changing in the latch cycle are captured.
    DigitX = 10'd40; DigitY = 10'd40; Value = 4'h7;
    step(0, 480, 1'b0);
    step(50, 41, 1'b1);
    idle2();
    check_now("latch_same_cycle", {1'b1, FG});

    // Randomized scans near the box with occasional unlatched input changes.
    for (int it = 0; it < 12; it++) begin
      DigitX = 10'($urandom_range(0, 639));
      DigitY = 10'($urandom_range(0, 479));
      Value = 4'($urandom_range(0, 15));
      step(0, 480, 1'b0);
      for (int k = 0; k < 400; k++) begin
        px = m_lx + int'($urandom_range(0, GW + 7)) - 4;
        py = m_ly + int'($urandom_range(0, GH + 7)) - 4;
        if (px < 0) px = 0;
        if (px > 1023) px = 1023;
        if (py < 0) py = 0;
        if (py > 1023) py = 1023;
        von = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 63) == 0) begin
          DigitX = 10'($urandom_range(0, 639));
          Value = 4'($urandom_range(0, 15));
        end
        step(px, py, von);
      end
    end
    idle2();

    // Reset mid-line while a lit pixel is on the output.
    DigitX = 10'd0; DigitY = 10'd0; Value = 4'h8;
    step(0, 480, 1'b0);
    step(5, 1, 1'b1);
    step(5, 1, 1'b1);
    step(5, 1, 1'b1);
    pulse_reset();
    step(5, 1, 1'b1);
    step(14, 25, 1'b1);
    step(700, 10, 1'b0);
    check_now("post_reset_first", {1'b1, FG});
    step(700, 10, 1'b0);
    check_now("post_reset_zero_shadow", {1'b0, BG});

    // 66 frames of a lit pixel; blinking (if built in) follows the latch count.
    DigitX = 10'd0; DigitY = 10'd0; Value = 4'h8;
    for (int f = 0; f < 66; f++) begin
      step(0, 480, 1'b0);
      step(5, 1, 1'b1);
      step(0, 25, 1'b1);
    end
    idle2();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
